regfile_wb_ctrl: RTL
====================

Name: regfile_wb_ctrl

Overview:
Write-back controller and load scoreboard placed between the execute/memory stages and the 16-entry register file.
- Drives the register file's two write ports: port 1 carries ALU results, the LDR port carries returning load data.
- Tracks destination registers of outstanding loads in an in-order pending queue.
- Back-pressures ALU write-back and load issue, and raises a read stall so operand reads never return stale data.

Parameters:
LDQ_DEPTH, 4, max outstanding loads (pending address queue depth, power of 2, >=2)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
alu_wb_valid  in  1  ALU result offered
alu_wb_addr  in  4  ALU destination register
alu_wb_data  in  32  ALU result
alu_wb_ready  out  1  ALU result accepted this cycle (comb)
ldr_issue_valid  in  1  load issued to memory
ldr_issue_addr  in  4  load destination register
ldr_issue_ready  out  1  load issue accepted this cycle (comb)
mem_rdata_valid  in  1  load data returned (in issue order)
mem_rdata  in  32  load data
rd_en  in  4  read-check enables {str, shift, B, A}
rd_addr_a / rd_addr_b / rd_addr_shift / rd_addr_str  in  4 each  operand read addresses
stall  out  1  operand hazard, hold decode/execute (comb)
w_en1 / w_addr1 / w_data1  out  1/4/32  register file port 1
w_en_ldr / w_addr_ldr / w_data_ldr  out  1/4/32  register file LDR port
busy_mask  out  15  bit i = load pending to Ri
pend_count  out  clog2(LDQ_DEPTH)+1  outstanding loads
proto_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (rst_n low at posedge): queue emptied, busy_mask=0, pend_count=0, all w_en*=0, w_addr*=0, w_data*=0, proto_err=0. Reset mid-operation discards all pending loads; later mem_rdata_valid pulses count as errors.
- alu_wb_ready = !busy_mask[alu_wb_addr] (WAW against a pending load). Address 15 is always ready.
- ALU accept = valid & ready, addr != 15. Next cycle: w_en1=1, w_addr1/w_data1 = the captured values (1-cycle latency). Otherwise w_en1=0.
- ALU valid to addr 15: accepted, no write, proto_err pulses next cycle.
- ldr_issue_ready = (pend_count < LDQ_DEPTH) & !busy_mask[ldr_issue_addr] & ldr_issue_addr != 15. Ready does not consider a completion in the same cycle.
- Issue accept: push the address, set its busy bit, pend_count+1 at the edge.
- Issue not ready: no state change. The requester holds.
- Completion (mem_rdata_valid, queue non-empty):
  - Pop the head address and clear its busy bit at the edge.
  - Next cycle: w_en_ldr=1, w_addr_ldr=head, w_data_ldr=mem_rdata.
- Completion with queue empty: ignored, proto_err pulses next cycle.
- Issue and completion in the same cycle: both occur, pend_count unchanged. If the issue address equals the head, the issue is not ready because the head is still busy.
- ALU and load write-back to different registers in the same cycle: both ports write together. Same-register conflicts cannot occur because ALU is blocked while that register is busy.
- Ordering: a load to Rn blocks ALU write-back to Rn until the busy bit clears. ALU then writes at least one cycle after the load write.
- stall = OR over enabled reads (rd_addr != 15) of any of:
  - busy_mask[rd_addr]
  - (w_en1 & w_addr1 == rd_addr)
  - (w_en_ldr & w_addr_ldr == rd_addr)
  These write hits cover writes not yet committed; there is no forwarding.
- Queue pointers wrap modulo LDQ_DEPTH.
- proto_err is the OR of both error sources, registered, one cycle wide per event.

Test Plan:
- Reset: drive rst_n=0 over 2 edges with stimulus active -> every output 0, alu_wb_ready=1, ldr_issue_ready=1.
- ALU write: valid, addr=3, data=0xDEADBEEF at cycle 0 -> cycle 1 w_en1=1, w_addr1=3, w_data1=0xDEADBEEF; rd_en[0]=1, rd_addr_a=3 in cycle 1 -> stall=1; cycle 2 -> stall=0.
- Load WAW: issue ldr to R5, then ALU valid to R5 -> alu_wb_ready=0 and busy_mask=0x0020. mem_rdata=0x12345678 -> next cycle w_en_ldr=1, w_addr_ldr=5; ALU accepted that same cycle; w_en1 to R5 the cycle after.
- Full queue: issue 4 loads to R1..R4 -> pend_count=4, ldr_issue_ready=0 for R6. Issue R6 in the same cycle as a completion -> still rejected; next cycle accepted.
- Wrap and order: 6 issue/complete pairs to R0..R5 with data 0x10..0x15 -> w_addr_ldr/w_data_ldr sequence 0/0x10 ... 5/0x15, pend_count returns to 0.
- Errors: mem_rdata_valid with queue empty -> proto_err=1 for exactly 1 cycle, no write. ALU to R15 -> proto_err pulse, w_en1=0. Reset with 3 loads pending -> busy_mask=0, and a following completion pulses proto_err.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Bus bundle between the execute/memory stages, the write-back controller and the register file.
// The controller uses the slave modport; the pipeline/bench side uses master.
interface regfile_wb_if #(
    parameter int LDQ_DEPTH = 4
);
    localparam int CW = $clog2(LDQ_DEPTH) + 1;

    logic          alu_wb_valid;
    logic [3:0]    alu_wb_addr;
    logic [31:0]   alu_wb_data;
    logic          alu_wb_ready;

    logic          ldr_issue_valid;
    logic [3:0]    ldr_issue_addr;
    logic          ldr_issue_ready;

    logic          mem_rdata_valid;
    logic [31:0]   mem_rdata;

    logic [3:0]    rd_en;
    logic [3:0]    rd_addr_a;
    logic [3:0]    rd_addr_b;
    logic [3:0]    rd_addr_shift;
    logic [3:0]    rd_addr_str;
    logic          stall;

    logic          w_en1;
    logic [3:0]    w_addr1;
    logic [31:0]   w_data1;
    logic          w_en_ldr;
    logic [3:0]    w_addr_ldr;
    logic [31:0]   w_data_ldr;

    logic [14:0]   busy_mask;
    logic [CW-1:0] pend_count;
    logic          proto_err;

    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        output alu_wb_ready,
        input  ldr_issue_valid, ldr_issue_addr,
        output ldr_issue_ready,
        input  mem_rdata_valid, mem_rdata,
        input  rd_en, rd_addr_a, rd_addr_b, rd_addr_shift, rd_addr_str,
        output stall,
        output w_en1, w_addr1, w_data1, w_en_ldr, w_addr_ldr, w_data_ldr,
        output busy_mask, pend_count, proto_err
    );

    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  alu_wb_ready,
        output ldr_issue_valid, ldr_issue_addr,
        input  ldr_issue_ready,
        output mem_rdata_valid, mem_rdata,
        output rd_en, rd_addr_a, rd_addr_b, rd_addr_shift, rd_addr_str,
        input  stall,
        input  w_en1, w_addr1, w_data1, w_en_ldr, w_addr_ldr, w_data_ldr,
        input  busy_mask, pend_count, proto_err
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller and in-order load scoreboard in front of the 16-entry register file.
// R15 is never written and never tracked; reads of R15 never stall.
module regfile_wb_ctrl #(
    parameter int LDQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_wb_if.slave  bus
);
    localparam int CW = $clog2(LDQ_DEPTH) + 1;
    localparam int PW = $clog2(LDQ_DEPTH);

    logic [3:0]    ldq [LDQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] pend_count;
    logic [14:0]   busy_mask;
    logic [15:0]   busy16;
    logic [15:0]   busy_next;
    logic [3:0]    head_addr;

    logic          w_en1;
    logic [3:0]    w_addr1;
    logic [31:0]   w_data1;
    logic          w_en_ldr;
    logic [3:0]    w_addr_ldr;
    logic [31:0]   w_data_ldr;
    logic          proto_err;

    logic          alu_ready;
    logic          alu_acc;
    logic          alu_write;
    logic          alu_err;
    logic          issue_ready;
    logic          issue_acc;
    logic          ldq_empty;
    logic          ldq_has_room;
    logic          cpl;
    logic          cpl_err;
    logic          stall;

    // Bit 15 is a permanent zero so R15 can be looked up without a range check.
    assign busy16       = {1'b0, busy_mask};
    assign head_addr    = ldq[rd_ptr];
    assign ldq_empty    = (pend_count == '0);
    assign ldq_has_room = (pend_count < CW'(LDQ_DEPTH));

    assign alu_ready = !busy16[bus.alu_wb_addr];
    assign alu_acc   = bus.alu_wb_valid && alu_ready;
    assign alu_write = alu_acc && (bus.alu_wb_addr != 4'd15);
    assign alu_err   = alu_acc && (bus.alu_wb_addr == 4'd15);

    // Ready deliberately ignores a same-cycle completion: freeing a slot or a busy bit
    // only takes effect from the next cycle.
    assign issue_ready = ldq_has_room && !busy16[bus.ldr_issue_addr]
                         && (bus.ldr_issue_addr != 4'd15);
    assign issue_acc   = bus.ldr_issue_valid && issue_ready;

    assign cpl     = bus.mem_rdata_valid && !ldq_empty;
    assign cpl_err = bus.mem_rdata_valid && ldq_empty;

    always_comb begin
        busy_next = busy16;
        if (cpl) begin
            busy_next[head_addr] = 1'b0;
        end
        if (issue_acc) begin
            busy_next[bus.ldr_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pend_count <= '0;
            busy_mask  <= '0;
        end else begin
            if (issue_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (cpl) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            pend_count <= pend_count + CW'(issue_acc) - CW'(cpl);
            busy_mask  <= busy_next[14:0];
        end
    end

    // Queue storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (issue_acc) begin
            ldq[wr_ptr] <= bus.ldr_issue_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_en1      <= 1'b0;
            w_addr1    <= '0;
            w_data1    <= '0;
            w_en_ldr   <= 1'b0;
            w_addr_ldr <= '0;
            w_data_ldr <= '0;
            proto_err  <= 1'b0;
        end else begin
            w_en1 <= alu_write;
            if (alu_write) begin
                w_addr1 <= bus.alu_wb_addr;
                w_data1 <= bus.alu_wb_data;
            end
            w_en_ldr <= cpl;
            if (cpl) begin
                w_addr_ldr <= head_addr;
                w_data_ldr <= bus.mem_rdata;
            end
            proto_err <= alu_err || cpl_err;
        end
    end

    // No forwarding: a register being written this cycle is still stale in the file.
    function automatic logic read_hazard(input logic [3:0] addr);
        logic hit;
        hit = busy16[addr]
              || (w_en1 && (w_addr1 == addr))
              || (w_en_ldr && (w_addr_ldr == addr));
        return (addr != 4'd15) && hit;
    endfunction

    always_comb begin
        stall = 1'b0;
        if (bus.rd_en[0] && read_hazard(bus.rd_addr_a))     stall = 1'b1;
        if (bus.rd_en[1] && read_hazard(bus.rd_addr_b))     stall = 1'b1;
        if (bus.rd_en[2] && read_hazard(bus.rd_addr_shift)) stall = 1'b1;
        if (bus.rd_en[3] && read_hazard(bus.rd_addr_str))   stall = 1'b1;
    end

    assign bus.alu_wb_ready    = alu_ready;
    assign bus.ldr_issue_ready = issue_ready;
    assign bus.stall           = stall;
    assign bus.w_en1           = w_en1;
    assign bus.w_addr1         = w_addr1;
    assign bus.w_data1         = w_data1;
    assign bus.w_en_ldr        = w_en_ldr;
    assign bus.w_addr_ldr      = w_addr_ldr;
    assign bus.w_data_ldr      = w_data_ldr;
    assign bus.busy_mask       = busy_mask;
    assign bus.pend_count      = pend_count;
    assign bus.proto_err       = proto_err;

endmodule
